// File: rtl/gaussian_filter_3x3_pkg.sv
// Shared image-processing constants for the 3x3 Gaussian filter: kernel weights,
// normalisation, rounding, pipeline widths and the position tag that travels with each window.
package gaussian_filter_3x3_pkg;

  // The kernel [1 2 1; 2 4 2; 1 2 1] is the outer product of the row weights (1,2,1).
  localparam int K_EDGE = 1;
  localparam int K_MID  = 2;

  localparam int NORM_SHIFT = 4;
  localparam int ROUND_ADD  = 8;

  function automatic int row_sum_width(input int data_width);
    return data_width + 2;
  endfunction

  function automatic int total_width(input int data_width);
    return data_width + 4;
  endfunction

  typedef struct packed {
    logic valid;
    logic border;
    logic eol;
    logic last;
  } tag_t;

endpackage

// File: rtl/gaussian_filter_3x3_row_sum.sv
// Registered row weighting a + 2b + c.
// The output is two bits wider than the inputs, so no carry is ever lost.
module gauss_row_sum
  import gaussian_filter_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              a,
  input  logic [DATA_WIDTH-1:0]              b,
  input  logic [DATA_WIDTH-1:0]              c,
  output logic [row_sum_width(DATA_WIDTH)-1:0] sum
);

  localparam int SW = row_sum_width(DATA_WIDTH);

  logic [SW-1:0] a_x;
  logic [SW-1:0] b_x;
  logic [SW-1:0] c_x;

  assign a_x = SW'(a);
  assign b_x = SW'(b);
  assign c_x = SW'(c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else begin
      sum <= SW'(K_EDGE) * a_x + SW'(K_MID) * b_x + SW'(K_EDGE) * c_x;
    end
  end

endmodule

// File: rtl/gaussian_filter_3x3.sv
// 3x3 Gaussian smoothing with a three-stage pipeline.
// Border windows pass the centre pixel through unfiltered.
module gaussian_filter_3x3
  import gaussian_filter_3x3_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  matrix_clken,
  input  logic [DATA_WIDTH-1:0] matrix_p11,
  input  logic [DATA_WIDTH-1:0] matrix_p12,
  input  logic [DATA_WIDTH-1:0] matrix_p13,
  input  logic [DATA_WIDTH-1:0] matrix_p21,
  input  logic [DATA_WIDTH-1:0] matrix_p22,
  input  logic [DATA_WIDTH-1:0] matrix_p23,
  input  logic [DATA_WIDTH-1:0] matrix_p31,
  input  logic [DATA_WIDTH-1:0] matrix_p32,
  input  logic [DATA_WIDTH-1:0] matrix_p33,
  output logic [DATA_WIDTH-1:0] gauss_data,
  output logic                  gauss_valid,
  output logic                  gauss_eol,
  output logic                  frame_done
);

  localparam int SW    = row_sum_width(DATA_WIDTH);
  localparam int TW    = total_width(DATA_WIDTH);
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] pos_col;
  logic [ROW_W-1:0] pos_row;
  logic             at_last_col;
  logic             at_last_row;
  tag_t             tag_in;

  // frame_start takes effect on the window sampled in the same cycle.
  always_comb begin
    pos_col     = frame_start ? '0 : col;
    pos_row     = frame_start ? '0 : row;
    at_last_col = (pos_col == COL_W'(WIDTH - 1));
    at_last_row = (pos_row == ROW_W'(DEPTH - 1));
    tag_in.valid  = matrix_clken;
    tag_in.border = (pos_col == '0) || at_last_col || (pos_row == '0) || at_last_row;
    tag_in.eol    = at_last_col;
    tag_in.last   = at_last_col && at_last_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (matrix_clken) begin
      col <= at_last_col ? '0 : pos_col + 1'b1;
      if (at_last_col) begin
        row <= at_last_row ? '0 : pos_row + 1'b1;
      end else begin
        row <= pos_row;
      end
    end else if (frame_start) begin
      col <= '0;
      row <= '0;
    end
  end

  logic [SW-1:0] r1;
  logic [SW-1:0] r2;
  logic [SW-1:0] r3;

  gauss_row_sum #(.DATA_WIDTH(DATA_WIDTH)) u_row1 (
    .clk(clk), .rst_n(rst_n), .a(matrix_p11), .b(matrix_p12), .c(matrix_p13), .sum(r1)
  );
  gauss_row_sum #(.DATA_WIDTH(DATA_WIDTH)) u_row2 (
    .clk(clk), .rst_n(rst_n), .a(matrix_p21), .b(matrix_p22), .c(matrix_p23), .sum(r2)
  );
  gauss_row_sum #(.DATA_WIDTH(DATA_WIDTH)) u_row3 (
    .clk(clk), .rst_n(rst_n), .a(matrix_p31), .b(matrix_p32), .c(matrix_p33), .sum(r3)
  );

  // Tags and the raw centre pixel ride alongside stages 1 and 2.
  tag_t                  tag_pipe    [2];
  logic [DATA_WIDTH-1:0] centre_pipe [2];
  logic [TW-1:0]         total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        tag_pipe[i]    <= '0;
        centre_pipe[i] <= '0;
      end
      total <= '0;
    end else begin
      tag_pipe[0]    <= tag_in;
      tag_pipe[1]    <= tag_pipe[0];
      centre_pipe[0] <= matrix_p22;
      centre_pipe[1] <= centre_pipe[0];
      total <= TW'(K_EDGE) * TW'(r1) + TW'(K_MID) * TW'(r2) + TW'(K_EDGE) * TW'(r3);
    end
  end

  // 16 * max pixel + 8 still fits TW bits, so the rounded result never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gauss_data  <= '0;
      gauss_valid <= 1'b0;
      gauss_eol   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      gauss_valid <= tag_pipe[1].valid;
      gauss_eol   <= tag_pipe[1].valid && tag_pipe[1].eol;
      frame_done  <= tag_pipe[1].valid && tag_pipe[1].last;
      if (tag_pipe[1].valid) begin
        gauss_data <= tag_pipe[1].border ? centre_pipe[1]
                                         : DATA_WIDTH'((total + TW'(ROUND_ADD)) >> NORM_SHIFT);
      end
    end
  end

endmodule
